// File: rtl/shift_exec_unit.sv
// Two-stage pipelined shift execution unit: LSR/LSL/ASR/ROR all map onto one
// funnel right shifter, with tagged results returned under valid/ready backpressure.
module shift_exec_unit #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_LSR = 2'b00,
    OP_LSL = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shiftOp_e;

  shiftOp_e           r_s1Op;
  logic               r_s1Valid;
  logic [WIDTH-1:0]   r_s1A;
  logic [SW-1:0]      r_s1Shamt;
  logic [TAG_W-1:0]   r_s1Tag;

  logic               r_s2Valid;
  logic [WIDTH-1:0]   r_s2Result;
  logic [TAG_W-1:0]   r_s2Tag;

  logic               w_s2Adv;
  logic               w_s1Adv;
  logic [WIDTH-1:0]   w_preA;
  logic [WIDTH-1:0]   w_fillHi;
  logic [2*WIDTH-1:0] w_funnel;
  logic [WIDTH-1:0]   w_shiftOut;
  logic [WIDTH-1:0]   w_result;

  function automatic logic [WIDTH-1:0] bitRev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] rev;
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = v[WIDTH-1-i];
    end
    return rev;
  endfunction

  assign w_s2Adv  = !r_s2Valid || out_ready;
  assign w_s1Adv  = !r_s1Valid || w_s2Adv;
  assign in_ready = w_s1Adv && !flush && !reset;

  assign out_valid  = r_s2Valid && !reset;
  assign out_result = r_s2Result;
  assign out_tag    = r_s2Tag;

  // The upper funnel half supplies the bits shifted in from the left:
  // zeros for LSR/LSL, sign copies for ASR, the operand itself for ROR.
  always_comb begin
    w_preA   = r_s1A;
    w_fillHi = '0;
    case (r_s1Op)
      OP_LSL:  w_preA   = bitRev(r_s1A);
      OP_ASR:  w_fillHi = {WIDTH{r_s1A[WIDTH-1]}};
      OP_ROR:  w_fillHi = r_s1A;
      default: w_fillHi = '0;
    endcase
    w_funnel   = {w_fillHi, w_preA};
    w_shiftOut = WIDTH'(w_funnel >> r_s1Shamt);
    w_result   = (r_s1Op == OP_LSL) ? bitRev(w_shiftOut) : w_shiftOut;
  end

  // Reset beats flush, which beats normal advance; data registers only load
  // when their stage advances so outputs stay stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1Valid  <= 1'b0;
      r_s1Op     <= OP_LSR;
      r_s1A      <= '0;
      r_s1Shamt  <= '0;
      r_s1Tag    <= '0;
      r_s2Valid  <= 1'b0;
      r_s2Result <= '0;
      r_s2Tag    <= '0;
    end else if (flush) begin
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
    end else begin
      if (w_s2Adv) begin
        r_s2Valid <= r_s1Valid;
        if (r_s1Valid) begin
          r_s2Result <= w_result;
          r_s2Tag    <= r_s1Tag;
        end
      end
      if (w_s1Adv) begin
        r_s1Valid <= in_valid;
        if (in_valid) begin
          r_s1Op    <= shiftOp_e'(in_op);
          r_s1A     <= in_a;
          r_s1Shamt <= in_shamt;
          r_s1Tag   <= in_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed and random checks of shift_exec_unit at WIDTH=16, TAG_W=4:
// arithmetic, latency, backpressure, flush, reset and full-rate streaming.
module tb_shift_exec_unit;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int SW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [SW-1:0]    in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_exec_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] refShift(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [SW-1:0] s);
    logic [WIDTH-1:0] r;
    case (op)
      2'd0: r = a >> s;
      2'd1: r = a << s;
      2'd2: r = $unsigned($signed(a) >>> s);
      default: begin
        r = a;
        for (int i = 0; i < int'(s); i++) r = {r[0], r[WIDTH-1:1]};
      end
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [SW-1:0] s, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_shamt = s; in_tag = tag;
  endtask

  // One op through an idle pipe: checks acceptance, latency and the result.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [WIDTH-1:0] a,
                               input logic [SW-1:0] s, input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] expRes);
    int n;
    drive(op, a, s, tag);
    out_ready = 1'b1;
    #1;
    checkOutput({name, "_rdy"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput({name, "_early"}, 32'(out_valid), 32'd0);
    n = 1;
    while (!out_valid && n < 8) begin
      step();
      n++;
    end
    checkOutput({name, "_lat"}, 32'(n), 32'd2);
    checkOutput({name, "_res"}, 32'(out_result), 32'(expRes));
    checkOutput({name, "_tag"}, 32'(out_tag), 32'(tag));
  endtask

  initial begin
    int k, seen, got, firstOut, lastOut, sent, stalls;
    logic acc;
    logic [TAG_W-1:0] tagsOut[$];
    logic [WIDTH+TAG_W-1:0] expQ[$];
    logic [WIDTH+TAG_W-1:0] expItem;
    logic [1:0] rop;
    logic [WIDTH-1:0] ra;
    logic [SW-1:0] rs;
    logic [TAG_W-1:0] rt;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0;
    in_shamt = '0; in_tag = '0; out_ready = 1'b0;
    step();
    checkOutput("rst_inrdy", 32'(in_ready), 32'd0);
    step();
    checkOutput("rst_ovalid", 32'(out_valid), 32'd0);
    checkOutput("rst_ores", 32'(out_result), 32'd0);
    checkOutput("rst_otag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    step();

    applyStimulus("lsr_basic", 2'd0, 16'hF000, 4'd4, 4'd3, 16'h0F00);
    applyStimulus("lsl15", 2'd1, 16'h0001, 4'd15, 4'd5, 16'h8000);
    applyStimulus("asr15", 2'd2, 16'h8000, 4'd15, 4'd6, 16'hFFFF);
    applyStimulus("asr2", 2'd2, 16'h4000, 4'd2, 4'd7, 16'h1000);
    applyStimulus("ror4", 2'd3, 16'h000F, 4'd4, 4'd8, 16'hF000);
    applyStimulus("lsr0", 2'd0, 16'hA5C3, 4'd0, 4'd9, 16'hA5C3);
    applyStimulus("lsl0", 2'd1, 16'hA5C3, 4'd0, 4'd10, 16'hA5C3);
    applyStimulus("asr0", 2'd2, 16'hA5C3, 4'd0, 4'd11, 16'hA5C3);
    applyStimulus("ror0", 2'd3, 16'hA5C3, 4'd0, 4'd12, 16'hA5C3);
    applyStimulus("lsl3", 2'd1, 16'h9123, 4'd3, 4'd13, 16'h8918);
    step();

    // Backpressure: only two ops fit while the output is blocked.
    out_ready = 1'b0;
    k = 1;
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 16'(k) * 16'h0101, 4'd0, 4'(k));
      #1;
      acc = in_ready;
      step();
      if (acc) k++;
    end
    checkOutput("bp_accepted", 32'(k - 1), 32'd2);
    checkOutput("bp_inrdy", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_tag", 32'(out_tag), 32'd1);
    checkOutput("bp_hold_res", 32'(out_result), 32'h0101);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && tagsOut.size() < 4; i++) begin
      if (k <= 4) drive(2'd0, 16'(k) * 16'h0101, 4'd0, 4'(k));
      else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) tagsOut.push_back(out_tag);
      step();
      if (acc) k++;
    end
    in_valid = 1'b0;
    checkOutput("bp_count", 32'(tagsOut.size()), 32'd4);
    for (int i = 0; i < tagsOut.size(); i++) checkOutput("bp_order", 32'(tagsOut[i]), 32'(i + 1));
    checkOutput("bp_nodup", 32'(out_valid), 32'd0);

    // Flush with both stages full; neither flushed tag may ever appear.
    out_ready = 1'b0;
    drive(2'd0, 16'h1111, 4'd1, 4'd5); step();
    drive(2'd0, 16'h2222, 4'd1, 4'd6); step();
    drive(2'd0, 16'h3333, 4'd1, 4'd7);
    flush = 1'b1;
    #1;
    checkOutput("fl_inrdy", 32'(in_ready), 32'd0);
    checkOutput("fl_full", 32'(out_valid), 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checkOutput("fl_ovalid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) seen++;
    end
    checkOutput("fl_ghost", 32'(seen), 32'd0);
    applyStimulus("fl_after", 2'd3, 16'h1234, 4'd8, 4'd14, 16'h3412);
    step();

    // Reset with two ops in flight.
    out_ready = 1'b0;
    drive(2'd0, 16'hFFFF, 4'd1, 4'd9); step();
    drive(2'd0, 16'hEEEE, 4'd1, 4'd10); step();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rm_inrdy", 32'(in_ready), 32'd0);
    checkOutput("rm_ovalid_dur", 32'(out_valid), 32'd0);
    step();
    checkOutput("rm_ovalid", 32'(out_valid), 32'd0);
    checkOutput("rm_ores", 32'(out_result), 32'd0);
    checkOutput("rm_otag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    applyStimulus("rm_after", 2'd2, 16'hC000, 4'd3, 4'd15, 16'hF800);
    step();

    // Full-rate random stream against the reference model.
    out_ready = 1'b1;
    sent = 0; got = 0; firstOut = -1; lastOut = -1; stalls = 0;
    for (int cyc = 0; cyc < 220 && got < 200; cyc++) begin
      if (sent < 200) begin
        rop = 2'($urandom_range(0, 3));
        ra  = 16'($urandom);
        rs  = 4'($urandom_range(0, 15));
        rt  = 4'($urandom_range(0, 15));
        drive(rop, ra, rs, rt);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        if (in_ready) begin
          expQ.push_back({refShift(rop, ra, rs), rt});
          sent++;
        end else begin
          stalls++;
        end
      end
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("tp_spurious", 32'(out_tag), 32'hFFFF_FFFF);
        end else begin
          expItem = expQ.pop_front();
          checkOutput("tp_item", 32'({out_result, out_tag}), 32'(expItem));
        end
        if (firstOut < 0) firstOut = cyc;
        lastOut = cyc;
        got++;
      end
      step();
    end
    in_valid = 1'b0;
    checkOutput("tp_got", 32'(got), 32'd200);
    checkOutput("tp_stalls", 32'(stalls), 32'd0);
    checkOutput("tp_first", 32'(firstOut), 32'd2);
    checkOutput("tp_last", 32'(lastOut), 32'd201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
